// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver and its BCD converter.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 cannot come out of the converter.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: binary value in, multiplexed digit/segment drive and busy out.
interface seg7_scan_driver_if #(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
);
  logic [IN_W-1:0]   num;
  logic [DIGITS-1:0] anode;
  logic [6:0]        cathode;
  logic              busy;

  modport master (output num, input anode, input cathode, input busy);
  modport slave  (input num, output anode, output cathode, output busy);
endinterface

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, free-running IDLE->SHIFT->LATCH loop.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       i_num,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CNT_W = $clog2(IN_W + 1);

  conv_state_t         r_state, w_state_nxt;
  logic [IN_W-1:0]     r_bin, w_bin_nxt;
  logic [4*DIGITS-1:0] r_bcd, w_bcd_nxt, w_adj;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_busy, w_busy_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        w_bin_nxt   = i_num;
        w_bcd_nxt   = '0;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        {w_bcd_nxt, w_bin_nxt} = {w_adj, r_bin} << 1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(IN_W - 1))
          w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_bcd  = r_bcd;
  assign o_busy = r_busy;
  assign o_done = (r_state == ST_LATCH);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: BCD conversion, display latch, digit scan, registered pin outputs.
// Optional leading-zero blanking is built when SEG7_LEAD_ZERO_BLANK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int IN_W        = 13,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [4*DIGITS-1:0] w_bcd;
  logic                w_busy;
  logic                w_done;

  logic [4*DIGITS-1:0] r_disp;
  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_anode;
  logic [6:0]          r_cathode;
  logic [3:0]          w_digit;
  logic                w_blank;

  bin2bcd_seq #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .i_num  (bus.num),
    .o_bcd  (w_bcd),
    .o_busy (w_busy),
    .o_done (w_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp <= '0;
    end else if (w_done) begin
      r_disp <= w_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_digit = r_disp[4*r_idx +: 4];

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_lead_zero;
  logic              w_run;

  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    w_lead_zero = '0;
    w_run       = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (r_disp[4*i +: 4] != 4'd0)
        w_run = 1'b0;
      w_lead_zero[i] = w_run;
    end
  end

  assign w_blank = w_lead_zero[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_anode   <= '1;
      r_cathode <= SEG_BLANK;
    end else begin
      r_anode   <= ~(DIGITS'(1) << r_idx);
      r_cathode <= w_blank ? SEG_BLANK : seg_encode(w_digit);
    end
  end

  assign bus.anode   = r_anode;
  assign bus.cathode = r_cathode;
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=4; expected display images are queued by stimulus.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.IN_W(13), .DIGITS(4)) u_if ();

  seg7_scan_driver #(
    .IN_W        (13),
    .DIGITS      (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int errors = 0;
  int checks = 0;
  int k;

  logic [27:0] q_img [$];
  string       q_name [$];

  // Edges since reset release; drives the bench's own scan and conversion timing model.
  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  function automatic logic [27:0] mk(input logic [6:0] c0, input logic [6:0] c1,
                                     input logic [6:0] c2, input logic [6:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Monitor: anode and busy every cycle from the model, cathode at each digit boundary from the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && k > 0) begin
        int          idx;
        logic [3:0]  exp_an;
        logic        exp_busy;
        logic [27:0] img;
        logic [6:0]  exp_c;
        string       nm;
        idx      = ((k - 1) / 4) % 4;
        exp_an   = ~(4'b0001 << idx);
        exp_busy = (((k - 1) % 15) != 14);
        checks++;
        if (u_if.anode !== exp_an) begin
          errors++;
          $display("FAIL anode k=%0d got=%b want=%b", k, u_if.anode, exp_an);
        end
        checks++;
        if (u_if.busy !== exp_busy) begin
          errors++;
          $display("FAIL busy k=%0d got=%b want=%b", k, u_if.busy, exp_busy);
        end
        if (((k - 1) % 4) == 0 && q_img.size() > 0) begin
          img   = q_img.pop_front();
          nm    = q_name.pop_front();
          exp_c = img[7*idx +: 7];
          checks++;
          if (u_if.cathode !== exp_c) begin
            errors++;
            $display("FAIL cathode %s digit%0d got=%h want=%h", nm, idx, u_if.cathode, exp_c);
          end
        end
      end
    end
  end

  task automatic push_img(input logic [27:0] img, input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      q_img.push_back(img);
      q_name.push_back(nm);
    end
  endtask

  task automatic wait_busy_fall(input string tag);
    bit seen_high;
    seen_high = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (u_if.busy === 1'b1) seen_high = 1'b1;
      else if (seen_high) return;
    end
    checks++;
    errors++;
    $display("FAIL busy_fall_timeout %s got=no_fall want=fall", tag);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100; n++) begin
      if (q_img.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout %s got=%0d want=0", tag, q_img.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (u_if.anode !== 4'b1111) begin
      errors++;
      $display("FAIL %s_anode got=%b want=1111", tag, u_if.anode);
    end
    checks++;
    if (u_if.cathode !== 7'h7F) begin
      errors++;
      $display("FAIL %s_cathode got=%h want=7f", tag, u_if.cathode);
    end
    checks++;
    if (u_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got=%b want=0", tag, u_if.busy);
    end
  endtask

  task automatic show_value(input logic [12:0] v, input logic [27:0] img, input string nm);
    @(negedge clk);
    u_if.num = v;
    wait_busy_fall(nm);
    wait_busy_fall(nm);
    @(posedge clk);
    push_img(img, nm, 4);
    drain(nm);
  endtask

  logic [27:0] img_1234, img_5678, img_8191, img_0, img_7;

  initial begin
    img_1234 = mk(7'h19, 7'h30, 7'h24, 7'h79);
    img_5678 = mk(7'h00, 7'h78, 7'h02, 7'h12);
    img_8191 = mk(7'h79, 7'h10, 7'h79, 7'h00);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    img_0    = mk(7'h40, 7'h7F, 7'h7F, 7'h7F);
    img_7    = mk(7'h78, 7'h7F, 7'h7F, 7'h7F);
`else
    img_0    = mk(7'h40, 7'h40, 7'h40, 7'h40);
    img_7    = mk(7'h78, 7'h40, 7'h40, 7'h40);
`endif

    u_if.num = 13'd1234;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");

    // Release, then expect the cleared display until the first conversion lands.
    @(negedge clk);
    #2 rst = 1'b1;
    push_img(img_0, "pre_conv", 4);
    begin
      int hi;
      hi = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (u_if.busy === 1'b1) hi++;
        else if (hi > 0) break;
      end
      checks++;
      if (hi != 14) begin
        errors++;
        $display("FAIL busy_len got=%0d want=14", hi);
      end
    end
    @(posedge clk);
    push_img(img_1234, "n1234", 4);
    drain("n1234");

    show_value(13'd8191, img_8191, "n8191");
    show_value(13'd0,    img_0,    "n0");
    show_value(13'd7,    img_7,    "n7");
    show_value(13'd1234, img_1234, "n1234b");

    // Change num on the third SHIFT cycle; the running conversion must still deliver 1234.
    wait_busy_fall("mid_a");
    repeat (3) @(negedge clk);
    u_if.num = 13'd5678;
    wait_busy_fall("mid_b");
    @(posedge clk);
    push_img(img_1234, "hold1234", 3);
    wait_busy_fall("mid_c");
    @(posedge clk);
    push_img(img_5678, "n5678", 4);
    drain("n5678");

    // Reset while digit 2 is lit and the converter is shifting.
    begin
      bit found;
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if ((((k - 1) / 4) % 4) == 2 && ((k - 1) % 15) <= 12) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL find_midscan got=none want=idx2_shift");
      end
    end
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("midrst_hold");
    @(negedge clk);
    #2 rst = 1'b1;
    push_img(img_0, "post_rst", 4);
    wait_busy_fall("post_rst");
    @(posedge clk);
    push_img(img_5678, "post_rst5678", 4);
    drain("post_rst5678");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
